// File: rtl/pipeline_wb_stage5_if.sv
// Writeback-stage bundle: MEM-side writeback inputs, mul/div result handshake,
// registered regfile write port and busy scoreboard.
interface pipeline_wb_stage5_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  logic            stall;
  logic            rf_wr_en_MEM;
  logic [RW-1:0]   rd_MEM;
  logic [1:0]      rf_wr_sel_MEM;
  logic [XLEN-1:0] alu_result_MEM;
  logic [XLEN-1:0] dm_rdata_MEM;
  logic [XLEN-1:0] pc_MEM;
  logic [XLEN-1:0] imm_MEM;

  logic            m_issue;
  logic [RW-1:0]   m_issue_rd;
  logic            m_done;
  logic [RW-1:0]   m_rd;
  logic [XLEN-1:0] m_result;
  logic            m_ready;

  logic            stall_req;
  logic            rf_wr_en;
  logic [RW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [NREG-1:0] busy;

  modport master (
    output stall, rf_wr_en_MEM, rd_MEM, rf_wr_sel_MEM,
           alu_result_MEM, dm_rdata_MEM, pc_MEM, imm_MEM,
           m_issue, m_issue_rd, m_done, m_rd, m_result,
    input  m_ready, stall_req, rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );

  modport slave (
    input  stall, rf_wr_en_MEM, rd_MEM, rf_wr_sel_MEM,
           alu_result_MEM, dm_rdata_MEM, pc_MEM, imm_MEM,
           m_issue, m_issue_rd, m_done, m_rd, m_result,
    output m_ready, stall_req, rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );
endinterface

// File: rtl/pipeline_wb_stage5.sv
// RV64 writeback stage: selects the MEM writeback value, merges mul/div results
// through a one-entry hold buffer, drives the registered regfile write port and busy scoreboard.
module pipeline_wb_stage5 #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic clk,
  input  logic reset,
  pipeline_wb_stage5_if.slave wb
);
  localparam int RW = $clog2(NREG);

  logic            hold_valid;
  logic [RW-1:0]   hold_rd;
  logic [XLEN-1:0] hold_data;

  logic            wr_en_q;
  logic [RW-1:0]   wr_addr_q;
  logic [XLEN-1:0] wr_data_q;
  logic            wr_is_m_q;
  logic [NREG-1:0] busy_q;

  logic [XLEN-1:0] pipe_val;
  logic            pipe_wr, m_ready_i, m_acc;
  logic            wr_en, wr_is_m, hold_fill;
  logic [RW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [NREG-1:0] set_mask, clr_mask, busy_nxt;

  always_comb begin
    case (wb.rf_wr_sel_MEM)
      2'b00:   pipe_val = wb.alu_result_MEM;
      2'b01:   pipe_val = wb.dm_rdata_MEM;
      2'b10:   pipe_val = wb.pc_MEM + XLEN'(4);
      default: pipe_val = wb.imm_MEM;
    endcase
  end

  assign pipe_wr      = wb.rf_wr_en_MEM & ~wb.stall & (wb.rd_MEM != '0);
  assign m_ready_i    = reset & ~hold_valid;
  // x0 results are accepted but never written or buffered
  assign m_acc        = wb.m_done & m_ready_i & (wb.m_rd != '0);
  assign wb.m_ready   = m_ready_i;
  assign wb.stall_req = reset & hold_valid & pipe_wr;

  // write port priority: hold buffer > pipeline > direct mul/div
  always_comb begin
    wr_en     = 1'b0;
    wr_is_m   = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    hold_fill = 1'b0;
    if (hold_valid) begin
      wr_en   = 1'b1;
      wr_is_m = 1'b1;
      wr_addr = hold_rd;
      wr_data = hold_data;
    end else if (pipe_wr) begin
      wr_en     = 1'b1;
      wr_addr   = wb.rd_MEM;
      wr_data   = pipe_val;
      hold_fill = m_acc;
    end else if (m_acc) begin
      wr_en   = 1'b1;
      wr_is_m = 1'b1;
      wr_addr = wb.m_rd;
      wr_data = wb.m_result;
    end
  end

  // busy clears when the mul/div write commits to the regfile; a same-cycle set wins
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wb.m_issue && wb.m_issue_rd != '0) set_mask = NREG'(1) << wb.m_issue_rd;
    if (wr_en_q && wr_is_m_q)              clr_mask = NREG'(1) << wr_addr_q;
    busy_nxt    = (busy_q & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_is_m_q  <= 1'b0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      busy_q     <= '0;
    end else begin
      wr_en_q   <= wr_en;
      wr_is_m_q <= wr_en & wr_is_m;
      if (wr_en) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      if (hold_valid) begin
        hold_valid <= 1'b0;
      end else if (hold_fill) begin
        hold_valid <= 1'b1;
        hold_rd    <= wb.m_rd;
        hold_data  <= wb.m_result;
      end
      busy_q <= busy_nxt;
    end
  end

  assign wb.rf_wr_en   = wr_en_q;
  assign wb.rf_wr_addr = wr_addr_q;
  assign wb.rf_wr_data = wr_data_q;
  assign wb.busy       = busy_q;
endmodule

// File: tb/tb_pipeline_wb_stage5.sv
// Directed bench for pipeline_wb_stage5: reset, writeback select, scoreboard,
// hold-buffer collision, set/clear race, stall and mid-operation reset.
module tb_pipeline_wb_stage5;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_wb_stage5_if #(.XLEN(64), .NREG(32)) wb_if ();

  pipeline_wb_stage5 #(.XLEN(64), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_if)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wb_if.stall          = 1'b0;
    wb_if.rf_wr_en_MEM   = 1'b0;
    wb_if.rd_MEM         = '0;
    wb_if.rf_wr_sel_MEM  = 2'b00;
    wb_if.alu_result_MEM = '0;
    wb_if.dm_rdata_MEM   = '0;
    wb_if.pc_MEM         = '0;
    wb_if.imm_MEM        = '0;
    wb_if.m_issue        = 1'b0;
    wb_if.m_issue_rd     = '0;
    wb_if.m_done         = 1'b0;
    wb_if.m_rd           = '0;
    wb_if.m_result       = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle();
    wb_if.m_done   = 1'b1;
    wb_if.m_rd     = 5'd5;
    wb_if.m_result = 64'h55;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy} !== '0) begin
        errors++;
        $display("FAIL reset_state: en=%0b addr=%0d data=%0h busy=%0h, want all 0",
                 wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy);
      end
      checks++;
      if ({wb_if.m_ready, wb_if.stall_req} !== 2'b00) begin
        errors++;
        $display("FAIL reset_hs: m_ready=%0b stall_req=%0b, want 0 0", wb_if.m_ready, wb_if.stall_req);
      end
    end
    reset = 1'b1;
    wb_if.m_done = 1'b0;
    #1;
    checks++;
    if (wb_if.m_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: m_ready=%0b want 1", wb_if.m_ready);
    end
  endtask

  task automatic test_pipe_select;
    logic [4:0]  rd_t  [5] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd31};
    logic [1:0]  sel_t [5] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    logic [63:0] pc_t  [5] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'h0, 64'h100};
    logic [63:0] exp_t [5] = '{64'h0, 64'h11, 64'h22, 64'h33, 64'h104};
    idle();
    wb_if.alu_result_MEM = 64'h11;
    wb_if.dm_rdata_MEM   = 64'h22;
    wb_if.imm_MEM        = 64'h33;
    wb_if.rf_wr_en_MEM   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wb_if.rd_MEM        = rd_t[i];
      wb_if.rf_wr_sel_MEM = sel_t[i];
      wb_if.pc_MEM        = pc_t[i];
      step();
      checks++;
      if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data} !== {1'b1, rd_t[i], exp_t[i]}) begin
        errors++;
        $display("FAIL pipe_sel%0d: got en=%0b addr=%0d data=%0h, want 1/%0d/%0h",
                 i, wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, rd_t[i], exp_t[i]);
      end
    end
    // rd=0 never writes; address and data hold
    wb_if.rd_MEM = 5'd0;
    step();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data} !== {1'b0, 5'd31, 64'h104}) begin
      errors++;
      $display("FAIL pipe_x0: got en=%0b addr=%0d data=%0h, want 0/31/104",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
    end
    idle();
  endtask

  task automatic test_scoreboard;
    idle();
    wb_if.m_issue    = 1'b1;
    wb_if.m_issue_rd = 5'd7;
    step();
    wb_if.m_issue = 1'b0;
    checks++;
    if (wb_if.busy !== 32'h80) begin
      errors++;
      $display("FAIL sb_set: busy=%0h want 80", wb_if.busy);
    end
    wb_if.m_done   = 1'b1;
    wb_if.m_rd     = 5'd7;
    wb_if.m_result = 64'h1234;
    step();
    wb_if.m_done = 1'b0;
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy} !== {1'b1, 5'd7, 64'h1234, 32'h80}) begin
      errors++;
      $display("FAIL sb_direct: en=%0b addr=%0d data=%0h busy=%0h, want 1/7/1234/80",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy);
    end
    step();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.busy} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL sb_clear: en=%0b busy=%0h, want 0/0", wb_if.rf_wr_en, wb_if.busy);
    end
  endtask

  task automatic test_collision;
    idle();
    wb_if.m_issue    = 1'b1;
    wb_if.m_issue_rd = 5'd9;
    step();
    wb_if.m_issue = 1'b0;
    // cycle N: pipeline rd3 and m_done rd9 together
    wb_if.rf_wr_en_MEM   = 1'b1;
    wb_if.rd_MEM         = 5'd3;
    wb_if.alu_result_MEM = 64'hA;
    wb_if.m_done         = 1'b1;
    wb_if.m_rd           = 5'd9;
    wb_if.m_result       = 64'hB;
    #1;
    checks++;
    if ({wb_if.m_ready, wb_if.stall_req} !== 2'b10) begin
      errors++;
      $display("FAIL col_n_hs: m_ready=%0b stall_req=%0b, want 1 0", wb_if.m_ready, wb_if.stall_req);
    end
    step();
    wb_if.m_done = 1'b0;
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data} !== {1'b1, 5'd3, 64'hA}) begin
      errors++;
      $display("FAIL col_n_wr: en=%0b addr=%0d data=%0h, want 1/3/a",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
    end
    // cycle N+1: buffer drains, pipeline rd4 must stall
    wb_if.rd_MEM         = 5'd4;
    wb_if.alu_result_MEM = 64'hC;
    #1;
    checks++;
    if ({wb_if.m_ready, wb_if.stall_req} !== 2'b01) begin
      errors++;
      $display("FAIL col_n1_hs: m_ready=%0b stall_req=%0b, want 0 1", wb_if.m_ready, wb_if.stall_req);
    end
    step();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy} !== {1'b1, 5'd9, 64'hB, 32'h200}) begin
      errors++;
      $display("FAIL col_n1_wr: en=%0b addr=%0d data=%0h busy=%0h, want 1/9/b/200",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy);
    end
    // cycle N+2: rd4 re-presented
    checks++;
    if ({wb_if.m_ready, wb_if.stall_req} !== 2'b10) begin
      errors++;
      $display("FAIL col_n2_hs: m_ready=%0b stall_req=%0b, want 1 0", wb_if.m_ready, wb_if.stall_req);
    end
    step();
    wb_if.rf_wr_en_MEM = 1'b0;
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy} !== {1'b1, 5'd4, 64'hC, 32'h0}) begin
      errors++;
      $display("FAIL col_n2_wr: en=%0b addr=%0d data=%0h busy=%0h, want 1/4/c/0",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy);
    end
    idle();
  endtask

  task automatic test_race;
    idle();
    wb_if.m_issue    = 1'b1;
    wb_if.m_issue_rd = 5'd6;
    step();
    wb_if.m_issue  = 1'b0;
    wb_if.m_done   = 1'b1;
    wb_if.m_rd     = 5'd6;
    wb_if.m_result = 64'h66;
    step();
    wb_if.m_done = 1'b0;
    // the rd6 result commits this cycle while rd6 is issued again
    wb_if.m_issue    = 1'b1;
    wb_if.m_issue_rd = 5'd6;
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data} !== {1'b1, 5'd6, 64'h66}) begin
      errors++;
      $display("FAIL race_wr: en=%0b addr=%0d data=%0h, want 1/6/66",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
    end
    step();
    wb_if.m_issue = 1'b0;
    step();
    checks++;
    if (wb_if.busy !== 32'h40) begin
      errors++;
      $display("FAIL race_busy: busy=%0h want 40", wb_if.busy);
    end
  endtask

  task automatic test_stall;
    idle();
    wb_if.stall          = 1'b1;
    wb_if.rf_wr_en_MEM   = 1'b1;
    wb_if.rd_MEM         = 5'd8;
    wb_if.alu_result_MEM = 64'h88;
    wb_if.m_done         = 1'b1;
    wb_if.m_rd           = 5'd10;
    wb_if.m_result       = 64'hAA;
    #1;
    checks++;
    if ({wb_if.m_ready, wb_if.stall_req} !== 2'b10) begin
      errors++;
      $display("FAIL stall_hs: m_ready=%0b stall_req=%0b, want 1 0", wb_if.m_ready, wb_if.stall_req);
    end
    step();
    idle();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data} !== {1'b1, 5'd10, 64'hAA}) begin
      errors++;
      $display("FAIL stall_direct: en=%0b addr=%0d data=%0h, want 1/10/aa",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
    end
    // stall alone: nothing written, port holds
    wb_if.stall        = 1'b1;
    wb_if.rf_wr_en_MEM = 1'b1;
    wb_if.rd_MEM       = 5'd8;
    step();
    idle();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data} !== {1'b0, 5'd10, 64'hAA}) begin
      errors++;
      $display("FAIL stall_nowr: en=%0b addr=%0d data=%0h, want 0/10/aa",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
    end
  endtask

  task automatic test_x0_result;
    idle();
    wb_if.rf_wr_en_MEM   = 1'b1;
    wb_if.rd_MEM         = 5'd2;
    wb_if.alu_result_MEM = 64'h2;
    wb_if.m_done         = 1'b1;
    wb_if.m_rd           = 5'd0;
    wb_if.m_result       = 64'hDEAD;
    step();
    wb_if.m_done = 1'b0;
    wb_if.rd_MEM = 5'd3;
    wb_if.alu_result_MEM = 64'h3;
    #1;
    checks++;
    if ({wb_if.m_ready, wb_if.stall_req} !== 2'b10) begin
      errors++;
      $display("FAIL x0_nobuf: m_ready=%0b stall_req=%0b, want 1 0", wb_if.m_ready, wb_if.stall_req);
    end
    step();
    idle();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data} !== {1'b1, 5'd3, 64'h3}) begin
      errors++;
      $display("FAIL x0_next: en=%0b addr=%0d data=%0h, want 1/3/3",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data);
    end
  endtask

  task automatic test_mid_reset;
    idle();
    wb_if.m_issue    = 1'b1;
    wb_if.m_issue_rd = 5'd12;
    step();
    wb_if.m_issue        = 1'b0;
    wb_if.rf_wr_en_MEM   = 1'b1;
    wb_if.rd_MEM         = 5'd1;
    wb_if.alu_result_MEM = 64'h1;
    wb_if.m_done         = 1'b1;
    wb_if.m_rd           = 5'd12;
    wb_if.m_result       = 64'hC0;
    step();
    idle();
    reset = 1'b0;
    step();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy, wb_if.m_ready} !== '0) begin
      errors++;
      $display("FAIL midreset: en=%0b addr=%0d data=%0h busy=%0h m_ready=%0b, want all 0",
               wb_if.rf_wr_en, wb_if.rf_wr_addr, wb_if.rf_wr_data, wb_if.busy, wb_if.m_ready);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({wb_if.rf_wr_en, wb_if.m_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midreset_drop: en=%0b m_ready=%0b, want 0 1", wb_if.rf_wr_en, wb_if.m_ready);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_pipe_select();
    test_scoreboard();
    test_collision();
    test_race();
    test_stall();
    test_x0_result();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_wb_stage5.md
# pipeline_wb_stage5

Writeback stage of the 5-stage RV64 pipeline: the write side of the register file that the register-read stage reads. Selects the writeback value for the instruction leaving MEM, merges out-of-band results from the multi-cycle mul/div unit through a one-entry hold buffer, and drives a registered write port. That port also serves as the WB forwarding source. Keeps a per-register busy scoreboard so the read stage can stall on pending mul/div destinations.

## Interface
- XLEN, 64, datapath width
- NREG, 32, architectural registers; x0 is hard-wired zero

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge
- stall  in  1  WB input register frozen; the MEM-side write is not consumed this cycle
- rf_wr_en_MEM  in  1  MEM instruction writes a register
- rd_MEM  in  5  destination register
- rf_wr_sel_MEM  in  2  source select: 00 alu_result, 01 dm_rdata, 10 pc_MEM+4, 11 imm_MEM
- alu_result_MEM, dm_rdata_MEM, pc_MEM, imm_MEM  in  XLEN each  candidate writeback values
- m_issue  in  1  a mul/div op leaves the register-read stage this cycle
- m_issue_rd  in  5  its destination
- m_done  in  1  mul/div result valid; held stable until accepted
- m_rd  in  5  mul/div destination
- m_result  in  XLEN  mul/div result
- m_ready  out  1  m_done accepted this cycle when m_done & m_ready; equals reset & ~hold_valid
- stall_req  out  1  combinational; asks upstream to freeze MEM this cycle
- rf_wr_en  out  1  registered regfile write enable
- rf_wr_addr  out  5  registered write address
- rf_wr_data  out  XLEN  registered write data
- busy  out  NREG  scoreboard; bit i = mul/div result for xi pending; bit 0 always 0

## Operation
- Pipeline value: the mux per rf_wr_sel_MEM; pc_MEM+4 wraps modulo 2^XLEN.
- A pipeline write is present when rf_wr_en_MEM & ~stall & rd_MEM!=0.
- Write port priority each cycle: hold buffer > pipeline write > direct m_done.
- Hold buffer valid:
  - The buffer entry is written to the regfile.
  - If a pipeline write is also present, stall_req=1 and that write is not consumed. Upstream re-presents it next cycle.
  - m_ready=0.
- Hold buffer empty, pipeline write present, and m_done:
  - The pipeline value is written.
  - The m_done result is accepted into the hold buffer (m_ready=1).
- Hold buffer empty, no pipeline write, and m_done:
  - The m_done result is written directly.
- m_done with m_rd=0 is accepted and discarded. No write occurs and no buffer entry is made.
- Scoreboard:
  - m_issue with m_issue_rd!=0 sets busy[m_issue_rd].
  - Writing a mul/div result to the regfile clears busy[rd]. Acceptance into the hold buffer does not clear it.
  - A set and a clear of the same bit in the same cycle: set wins.
- No write occurs: rf_wr_en=0; rf_wr_addr and rf_wr_data hold their previous values.
- rf_wr_addr is never 0 when rf_wr_en=1.

## Timing
- Reset (reset=0 at an edge): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, busy=0, hold buffer empty. m_ready=0 while reset=0. stall_req=0.
- Reset asserted mid-operation discards the held result and all busy bits at that edge.
- Latency: a value selected in cycle N appears on rf_wr_* after edge N. The regfile commits it at edge N+1.
- Hold buffer: fills at edge N. It is written out in cycle N+1, so it appears on rf_wr_* after edge N+1. m_ready returns to 1 in cycle N+2.
- stall_req is asserted only in cycles where the hold buffer is valid and a pipeline write is present. Each such assertion lasts one cycle.
- The busy update is visible one cycle after the m_issue edge.

## Test plan
- Reset: hold reset=0 for 2 cycles with m_done=1. Required: all outputs 0, m_ready=0, busy=0. Release: m_ready=1.
- Pipeline select: rd_MEM=5, sel=10, pc_MEM=0xFFFF_FFFF_FFFF_FFFC. Required next cycle: rf_wr_en=1, addr=5, data=0. Repeat with rd_MEM=0. Required: rf_wr_en=0.
- Scoreboard: m_issue rd=7, then m_done rd=7 data=0x1234 with no pipeline write. Required: busy[7]=1, then a direct write of 7/0x1234, then busy[7]=0 on the next cycle.
- Collision:
  - Cycle N: pipeline write rd=3 data=0xA and m_done rd=9 data=0xB. Required: after N, write 3/0xA; hold buffer filled.
  - Cycle N+1: pipeline write rd=4 data=0xC. Required: after N+1, write 9/0xB with stall_req=1 in N+1, m_ready=0.
  - Cycle N+2: rd=4 re-presented. Required: after N+2, write 4/0xC, then busy[9]=0 and m_ready=1.
- Set/clear race: busy[6]=1; the rd=6 result is written in the same cycle as m_issue rd=6. Required: busy[6] stays 1.
- Stall: stall=1 with a valid pipeline write. Required: no write on the next cycle. An m_done arriving in the same cycle is written directly.
